// File: rtl/condicionador_botoes_pkg.sv
// rtl/condicionador_botoes_pkg.sv - shared state encodings and one-hot helper
// Imported by the button conditioner and its testbench.
package condicionador_botoes_pkg;

  typedef enum logic [2:0] {
    ESTADO_OCIOSO        = 3'd0,
    ESTADO_FILTRANDO     = 3'd1,
    ESTADO_EMITE         = 3'd2,
    ESTADO_ESPERA_SOLTAR = 3'd3
  } estado_t;

  // Exactly one bit set; callers zero-extend narrower vectors.
  function automatic logic eh_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// rtl/condicionador_botoes_if.sv - button-side and game-side signals of the conditioner
// master drives the raw buttons and controls; slave is the conditioner itself.
interface condicionador_botoes_if #(
  parameter int N_BOTOES = 4
);
  logic [N_BOTOES-1:0] botoes;
  logic                habilita;
  logic                limpa;
  logic [N_BOTOES-1:0] jogada;
  logic                jogada_feita;
  logic                tem_jogada;
  logic [2:0]          db_estado;

  modport master (
    output botoes, habilita, limpa,
    input  jogada, jogada_feita, tem_jogada, db_estado
  );

  modport slave (
    input  botoes, habilita, limpa,
    output jogada, jogada_feita, tem_jogada, db_estado
  );
endinterface

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// rtl/condicionador_botoes_sincronizador_2ff.sv - two-flop synchroniser for raw button levels
// Only instantiated when CONDICIONADOR_BOTOES_SYNC_EN is defined.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sinc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d;
      sinc_q <= meta_q;
    end
  end

  assign q = sinc_q;

endmodule

// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - debounce, one-hot validation and press pulse for player buttons
// Define CONDICIONADOR_BOTOES_SYNC_EN to put a 2-FF synchroniser in front of the filter.
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 2,
  parameter int CONT_W          = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  condicionador_botoes_if.slave bus
);

  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(DEBOUNCE_CICLOS);
  localparam logic [CONT_W-1:0] UM     = CONT_W'(1);

  logic [N_BOTOES-1:0] s;

`ifdef CONDICIONADOR_BOTOES_SYNC_EN
  sincronizador_2ff #(.WIDTH(N_BOTOES)) u_sincronizador (
    .clock (clock),
    .reset (reset),
    .d     (bus.botoes),
    .q     (s)
  );
`else
  assign s = bus.botoes;
`endif

  estado_t             estado_q, estado_d;
  logic [CONT_W-1:0]   cnt_q, cnt_d;
  logic [N_BOTOES-1:0] amostra_q, amostra_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                jogada_feita_q, jogada_feita_d;

  logic                s_vazio;
  logic                s_one_hot;
  logic [CONT_W-1:0]   cnt_inc;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    amostra_d = amostra_q;
    jogada_d  = jogada_q;
    s_vazio   = (s == '0);
    s_one_hot = eh_one_hot(32'(s));
    cnt_inc   = cnt_q + UM;

    unique case (estado_q)
      ESTADO_OCIOSO: begin
        if (bus.habilita) begin
          if (s_one_hot) begin
            amostra_d = s;
            cnt_d     = UM;
            estado_d  = (UM >= LIMITE) ? ESTADO_EMITE : ESTADO_FILTRANDO;
          end else if (!s_vazio) begin
            cnt_d    = '0;
            estado_d = ESTADO_ESPERA_SOLTAR;
          end
        end
      end
      ESTADO_FILTRANDO: begin
        if (!bus.habilita || (!s_vazio && !s_one_hot)) begin
          cnt_d    = '0;
          estado_d = ESTADO_ESPERA_SOLTAR;
        end else if (s_vazio) begin
          cnt_d    = '0;
          estado_d = ESTADO_OCIOSO;
        end else if (s != amostra_q) begin
          // A different single button restarts the filter from its first sample.
          amostra_d = s;
          cnt_d     = UM;
          if (UM >= LIMITE) estado_d = ESTADO_EMITE;
        end else if (cnt_inc >= LIMITE) begin
          estado_d = ESTADO_EMITE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ESTADO_EMITE: begin
        cnt_d    = '0;
        estado_d = ESTADO_ESPERA_SOLTAR;
      end
      ESTADO_ESPERA_SOLTAR: begin
        if (!s_vazio) begin
          cnt_d = '0;
        end else if (cnt_inc >= LIMITE) begin
          cnt_d    = '0;
          estado_d = ESTADO_OCIOSO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d    = '0;
        estado_d = ESTADO_OCIOSO;
      end
    endcase

    if (estado_d == ESTADO_EMITE) cnt_d = '0;

    // An accepted press overrides a same-cycle clear.
    if (bus.limpa) jogada_d = '0;
    if (estado_d == ESTADO_EMITE) jogada_d = amostra_d;

    jogada_feita_d = (estado_d == ESTADO_EMITE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q       <= ESTADO_OCIOSO;
      cnt_q          <= '0;
      amostra_q      <= '0;
      jogada_q       <= '0;
      jogada_feita_q <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      cnt_q          <= cnt_d;
      amostra_q      <= amostra_d;
      jogada_q       <= jogada_d;
      jogada_feita_q <= jogada_feita_d;
    end
  end

  assign bus.jogada       = jogada_q;
  assign bus.jogada_feita = jogada_feita_q;
  assign bus.db_estado    = estado_q;
  assign bus.tem_jogada   = (estado_q == ESTADO_EMITE) ||
                            ((estado_q == ESTADO_ESPERA_SOLTAR) && (s == amostra_q) && (amostra_q != '0));

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - directed bench with a pulse scoreboard for condicionador_botoes
// Define CONDICIONADOR_BOTOES_SYNC_EN for both RTL and bench to cover the synchronised build.
module tb_condicionador_botoes;

`ifdef CONDICIONADOR_BOTOES_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [31:0] S_OCIOSO = 32'd0;
  localparam logic [31:0] S_FILTR  = 32'd1;
  localparam logic [31:0] S_EMITE  = 32'd2;
  localparam logic [31:0] S_ESPERA = 32'd3;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [3:0] esperado_q[$];

  condicionador_botoes_if #(.N_BOTOES(4)) bus ();

  condicionador_botoes #(
    .N_BOTOES        (4),
    .DEBOUNCE_CICLOS (2),
    .CONT_W          (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Every jogada_feita pulse must match the oldest expected press code.
  initial begin
    logic [3:0] exp_code;
    forever begin
      @(negedge clock);
      if (bus.jogada_feita === 1'b1) begin
        if (esperado_q.size() == 0) begin
          chk("pulso_inesperado", 32'(bus.jogada), 32'hFFFF_FFFF);
        end else begin
          exp_code = esperado_q.pop_front();
          chk("pulso_codigo", 32'(bus.jogada), 32'(exp_code));
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.botoes   = 4'b0000;
    bus.habilita = 1'b0;
    bus.limpa    = 1'b0;
    tick(2);
    chk("rst_estado", 32'(bus.db_estado), S_OCIOSO);
    chk("rst_jogada", 32'(bus.jogada), 32'd0);
    chk("rst_feita", 32'(bus.jogada_feita), 32'd0);
    chk("rst_tem", 32'(bus.tem_jogada), 32'd0);
    reset = 1'b1;
    tick(1);

    // 1: clean 3-cycle press
    bus.habilita = 1'b1;
    bus.botoes   = 4'b0100;
    esperado_q.push_back(4'b0100);
    tick(LAT + 1);
    chk("t1_filtrando", 32'(bus.db_estado), S_FILTR);
    tick(1);
    chk("t1_emite", 32'(bus.db_estado), S_EMITE);
    chk("t1_feita", 32'(bus.jogada_feita), 32'd1);
    chk("t1_jogada", 32'(bus.jogada), 32'h4);
    chk("t1_tem_emite", 32'(bus.tem_jogada), 32'd1);
    tick(1);
    chk("t1_espera", 32'(bus.db_estado), S_ESPERA);
    chk("t1_tem_espera", 32'(bus.tem_jogada), 32'd1);
    bus.botoes = 4'b0000;
    tick(LAT + 1);
    chk("t1_espera_rel", 32'(bus.db_estado), S_ESPERA);
    tick(1);
    chk("t1_ocioso", 32'(bus.db_estado), S_OCIOSO);

    // 2: one-cycle glitch
    bus.botoes = 4'b0001;
    tick(1);
    bus.botoes = 4'b0000;
    tick(LAT);
    chk("t2_filtrando", 32'(bus.db_estado), S_FILTR);
    tick(1);
    chk("t2_ocioso", 32'(bus.db_estado), S_OCIOSO);
    chk("t2_jogada", 32'(bus.jogada), 32'h4);

    // 3: multi-hot press held 5 cycles
    bus.botoes = 4'b0011;
    tick(LAT + 1);
    chk("t3_espera", 32'(bus.db_estado), S_ESPERA);
    tick(4);
    chk("t3_espera_hold", 32'(bus.db_estado), S_ESPERA);
    bus.botoes = 4'b0000;
    tick(LAT + 1);
    chk("t3_espera_rel", 32'(bus.db_estado), S_ESPERA);
    tick(1);
    chk("t3_ocioso", 32'(bus.db_estado), S_OCIOSO);
    chk("t3_jogada", 32'(bus.jogada), 32'h4);

    // 4: long hold never re-triggers
    bus.botoes = 4'b1000;
    esperado_q.push_back(4'b1000);
    tick(LAT + 2);
    chk("t4_emite", 32'(bus.db_estado), S_EMITE);
    for (int i = 0; i < 18; i++) begin
      tick(1);
      chk("t4_tem_hold", 32'(bus.tem_jogada), 32'd1);
    end
    chk("t4_espera", 32'(bus.db_estado), S_ESPERA);
    bus.botoes = 4'b0000;
    tick(LAT + 1);
    chk("t4_tem_rel", 32'(bus.tem_jogada), 32'd0);
    chk("t4_espera_rel", 32'(bus.db_estado), S_ESPERA);
    tick(1);
    chk("t4_ocioso", 32'(bus.db_estado), S_OCIOSO);
    chk("t4_jogada", 32'(bus.jogada), 32'h8);

    // 5: press while disabled, then enable dropped mid-filter
    bus.habilita = 1'b0;
    bus.botoes   = 4'b0010;
    tick(LAT + 4);
    chk("t5_ignorado", 32'(bus.db_estado), S_OCIOSO);
    bus.botoes = 4'b0000;
    tick(LAT + 1);
    bus.habilita = 1'b1;
    bus.botoes   = 4'b0010;
    tick(LAT + 1);
    chk("t5_filtrando", 32'(bus.db_estado), S_FILTR);
    bus.habilita = 1'b0;
    tick(1);
    chk("t5_espera", 32'(bus.db_estado), S_ESPERA);
    bus.botoes   = 4'b0000;
    bus.habilita = 1'b1;
    tick(LAT + 2);
    chk("t5_ocioso", 32'(bus.db_estado), S_OCIOSO);
    chk("t5_jogada", 32'(bus.jogada), 32'h8);

    // 6a: asynchronous reset mid-filter, held button accepted afterwards
    bus.botoes = 4'b0001;
    tick(LAT + 1);
    chk("t6_filtrando", 32'(bus.db_estado), S_FILTR);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_estado", 32'(bus.db_estado), S_OCIOSO);
    chk("t6_rst_jogada", 32'(bus.jogada), 32'd0);
    chk("t6_rst_feita", 32'(bus.jogada_feita), 32'd0);
    chk("t6_rst_tem", 32'(bus.tem_jogada), 32'd0);
    #1 reset = 1'b1;
    esperado_q.push_back(4'b0001);
    tick(LAT + 1);
    chk("t6_refiltra", 32'(bus.db_estado), S_FILTR);
    tick(1);
    chk("t6_emite", 32'(bus.db_estado), S_EMITE);
    chk("t6_jogada", 32'(bus.jogada), 32'h1);
    bus.botoes = 4'b0000;
    tick(LAT + 3);
    chk("t6_ocioso", 32'(bus.db_estado), S_OCIOSO);

    // 6b: clear coinciding with a load, then clear alone
    bus.botoes = 4'b0100;
    esperado_q.push_back(4'b0100);
    tick(LAT + 1);
    bus.limpa = 1'b1;
    tick(1);
    bus.limpa = 1'b0;
    chk("t6b_load_vence", 32'(bus.jogada), 32'h4);
    chk("t6b_emite", 32'(bus.db_estado), S_EMITE);
    tick(1);
    bus.limpa = 1'b1;
    tick(1);
    bus.limpa = 1'b0;
    chk("t6b_limpa", 32'(bus.jogada), 32'd0);
    chk("t6b_fsm_intacta", 32'(bus.db_estado), S_ESPERA);
    bus.botoes = 4'b0000;
    tick(LAT + 3);
    chk("t6b_ocioso", 32'(bus.db_estado), S_OCIOSO);

    tick(2);
    chk("fila_vazia", 32'(esperado_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
